usb_ep_rd_stream: RTL and testbench

USB_EP_RD_STREAM -- requirements
Module: usb_ep_rd_stream

---
 rtl/usb_ep_rd_stream_if.sv | 30 +++
 rtl/usb_ep_rd_stream.sv | 167 ++++++++++++++++
 tb/tb_usb_ep_rd_stream.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_ep_rd_stream_if.sv
// Bundle of command, endpoint-buffer read port and byte-stream signals for usb_ep_rd_stream.
// The slave modport is the streamer's view; master is the surrounding logic's view.
interface usb_ep_rd_stream_if #(
  parameter int AWIDTH = 11,
  parameter int LWIDTH = 10
);
  logic              cmd_start;
  logic [AWIDTH-1:0] cmd_addr;
  logic [LWIDTH-1:0] cmd_len;
  logic              cmd_ready;
  logic              abort;
  logic [AWIDTH-1:0] buf_rd_addr_0;
  logic              buf_rd_en_0;
  logic [7:0]        buf_rd_data_1;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              done;

  modport slave (
    input  cmd_start, cmd_addr, cmd_len, abort, buf_rd_data_1, out_ready,
    output cmd_ready, buf_rd_addr_0, buf_rd_en_0, out_data, out_valid, out_last, done
  );

  modport master (
    output cmd_start, cmd_addr, cmd_len, abort, buf_rd_data_1, out_ready,
    input  cmd_ready, buf_rd_addr_0, buf_rd_en_0, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/usb_ep_rd_stream.sv
// Streams one packet out of an endpoint buffer (1-cycle read latency) as a valid/ready
// byte stream through a 2-entry registered FIFO.
//
// state | meaning
// IDLE  | waiting for cmd_start, cmd_ready=1
// FETCH | issuing buffer reads while FIFO credit allows
// DRAIN | all reads issued, waiting for the last byte handshake
// DONE  | one-cycle done pulse
module usb_ep_rd_stream #(
  parameter int AWIDTH = 11,
  parameter int LWIDTH = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  usb_ep_rd_stream_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [LWIDTH-1:0] rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [1:0]        count_q, count_d;
  logic [7:0]        head_data_q, head_data_d;
  logic [7:0]        tail_data_q, tail_data_d;
  logic              head_last_q, head_last_d;
  logic              tail_last_q, tail_last_d;

  logic              pop;
  logic              push;
  logic              rd_issue;
  logic [2:0]        occ_sum;

  // Credit check counts the byte in flight and frees the slot popped this cycle,
  // so back-to-back reads sustain one byte per cycle without overflowing the FIFO.
  always_comb begin
    pop      = (count_q != 2'd0) && bus.out_ready;
    push     = inflight_q;
    occ_sum  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue = (state_q == S_FETCH) && (rem_q != '0) && (occ_sum < 3'd2) && !bus.abort;
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue && (rem_q == LWIDTH'(1));

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_start) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = (bus.cmd_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_issue) begin
          addr_d = addr_q + AWIDTH'(1);
          rem_d  = rem_q - LWIDTH'(1);
          if (rem_q == LWIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d    = S_IDLE;
      rem_d      = '0;
      inflight_d = 1'b0;
    end
  end

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = bus.buf_rd_data_1;
          head_last_d = inflight_last_q;
        end else begin
          tail_data_d = bus.buf_rd_data_1;
          tail_last_d = inflight_last_q;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = bus.buf_rd_data_1;
          head_last_d = inflight_last_q;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = bus.buf_rd_data_1;
          tail_last_d = inflight_last_q;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase

    if (bus.abort) begin
      count_d     = 2'd0;
      head_last_d = 1'b0;
      tail_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      head_data_q     <= 8'd0;
      head_last_q     <= 1'b0;
      tail_data_q     <= 8'd0;
      tail_last_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      head_data_q     <= head_data_d;
      head_last_q     <= head_last_d;
      tail_data_q     <= tail_data_d;
      tail_last_q     <= tail_last_d;
    end
  end

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.buf_rd_en_0   = rd_issue;
  assign bus.buf_rd_addr_0 = addr_q;
  assign bus.out_data      = head_data_q;
  assign bus.out_valid     = (count_q != 2'd0);
  assign bus.out_last      = head_last_q && (count_q != 2'd0);
  assign bus.done          = (state_q == S_DONE);

endmodule

// File: tb/tb_usb_ep_rd_stream.sv
// Directed bench for usb_ep_rd_stream: a packet-level model (expected byte and read-address
// queues derived from start address/length) is compared against the DUT every cycle.
module tb_usb_ep_rd_stream;
  localparam int AW = 11;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_ep_rd_stream_if #(.AWIDTH(AW), .LWIDTH(LW)) bus ();
  usb_ep_rd_stream #(.AWIDTH(AW), .LWIDTH(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [2048];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.buf_rd_en_0) bus.buf_rd_data_1 <= mem[bus.buf_rd_addr_0];

  logic [8:0]  exp_q[$];
  logic [10:0] exp_addr_q[$];
  int          outstanding = 0;
  bit          done_pend = 1'b0;

  logic [10:0] rd_addr_log[$];
  int          rd_cyc_log[$];
  logic [7:0]  byte_log[$];
  int          byte_cyc_log[$];
  int          last_cyc = -1;
  int          done_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.buf_rd_en_0) begin
        chk("rd_pending", 32'(exp_addr_q.size() != 0), 1);
        chk("rd_en_state", 32'(bus.cmd_ready | bus.done), 0);
        if (exp_addr_q.size() != 0) chk("rd_addr", 32'(bus.buf_rd_addr_0), 32'(exp_addr_q.pop_front()));
        rd_addr_log.push_back(bus.buf_rd_addr_0);
        rd_cyc_log.push_back(cyc);
        outstanding++;
      end
      if (bus.out_valid) begin
        chk("byte_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q[0][7:0]));
          chk("out_last", 32'(bus.out_last), 32'(exp_q[0][8]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            byte_log.push_back(bus.out_data);
            byte_cyc_log.push_back(cyc);
            outstanding--;
            if (bus.out_last) last_cyc = cyc;
          end
        end
      end
      chk("outstanding", 32'(outstanding <= 2), 1);
      if (bus.done) begin
        chk("done_expected", 32'(done_pend && exp_q.size() == 0), 1);
        done_pend = 1'b0;
        done_cyc  = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr_q.delete();
    outstanding = 0;
    done_pend   = 1'b0;
  endtask

  task automatic clear_logs();
    rd_addr_log.delete();
    rd_cyc_log.delete();
    byte_log.delete();
    byte_cyc_log.delete();
    last_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic send(input logic [10:0] a, input logic [9:0] l, output int n);
    int t = 0;
    while (!bus.cmd_ready && t < 100) begin tick(); t++; end
    chk("send_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_start = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    n = cyc;
    for (int i = 0; i < int'(l); i++) begin
      logic [10:0] ad;
      ad = a + 11'(i);
      exp_addr_q.push_back(ad);
      exp_q.push_back({(i == int'(l) - 1), mem[ad]});
    end
    done_pend = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || done_pend || !bus.cmd_ready) && t < budget) begin
      tick();
      t++;
    end
    chk("idle_timeout", 32'(t < budget), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [63:0] pat;
    pat = 64'b1011_0000_0011_0110_0000_0001_1101_0011_1000_0011_0101_1110_0000_0111_0101_1011;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 11);
    bus.cmd_start = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_rd_en", 32'(bus.buf_rd_en_0), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rd_addr", 32'(bus.buf_rd_addr_0), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    #20 rst_n = 1'b1;
    tick();

    // Basic packet: cycle-exact read, byte, last and done timing.
    clear_logs();
    send(11'h010, 10'd4, n);
    wait_idle(50);
    chk("t1_nreads", 32'(rd_cyc_log.size()), 4);
    chk("t1_rd0_cyc", 32'(rd_cyc_log[0]), 32'(n + 1));
    chk("t1_rd3_cyc", 32'(rd_cyc_log[3]), 32'(n + 4));
    chk("t1_rd3_addr", 32'(rd_addr_log[3]), 32'h013);
    chk("t1_b0_cyc", 32'(byte_cyc_log[0]), 32'(n + 3));
    chk("t1_b3_cyc", 32'(byte_cyc_log[3]), 32'(n + 6));
    chk("t1_last_cyc", 32'(last_cyc), 32'(n + 6));
    chk("t1_done_cyc", 32'(done_cyc), 32'(n + 7));
    chk("t1_b0_data", 32'(byte_log[0]), 32'h5B);

    // Zero-length packet.
    clear_logs();
    send(11'h050, 10'd0, n);
    chk("t2_done_n1", 32'(bus.done), 1);
    tick();
    chk("t2_ready_n2", 32'(bus.cmd_ready), 1);
    chk("t2_done_n2", 32'(bus.done), 0);
    wait_idle(20);
    chk("t2_nreads", 32'(rd_cyc_log.size()), 0);
    chk("t2_nbytes", 32'(byte_log.size()), 0);
    chk("t2_done_cyc", 32'(done_cyc), 32'(n + 1));

    // Address wrap.
    clear_logs();
    send(11'h7FE, 10'd4, n);
    wait_idle(50);
    chk("t3_a0", 32'(rd_addr_log[0]), 32'h7FE);
    chk("t3_a1", 32'(rd_addr_log[1]), 32'h7FF);
    chk("t3_a2", 32'(rd_addr_log[2]), 32'h000);
    chk("t3_a3", 32'(rd_addr_log[3]), 32'h001);
    chk("t3_b0", 32'(byte_log[0]), 32'hC1);
    chk("t3_b1", 32'(byte_log[1]), 32'hE6);
    chk("t3_b2", 32'(byte_log[2]), 32'h0B);
    chk("t3_b3", 32'(byte_log[3]), 32'h30);

    // Backpressure with long stalls; a stray cmd_start mid-packet must be ignored.
    clear_logs();
    bus.out_ready = 1'b0;
    send(11'h123, 10'd8, n);
    k = 0;
    while ((exp_q.size() != 0 || done_pend || !bus.cmd_ready) && k < 400) begin
      bus.out_ready = pat[k % 64];
      bus.cmd_start = (k == 2);
      bus.cmd_addr  = 11'h300;
      bus.cmd_len   = 10'd3;
      tick();
      k++;
    end
    bus.cmd_start = 1'b0;
    chk("t4_timeout", 32'(k < 400), 1);
    chk("t4_nbytes", 32'(byte_log.size()), 8);
    chk("t4_nreads", 32'(rd_addr_log.size()), 8);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("t4_no_extra", 32'(byte_log.size()), 8);

    // Abort with two bytes queued, then a clean follow-up packet.
    clear_logs();
    bus.out_ready = 1'b0;
    send(11'h100, 10'd6, n);
    repeat (3) tick();
    chk("t5_queued_valid", 32'(bus.out_valid), 1);
    bus.abort = 1'b1;
    @(posedge clk);
    clear_model();
    #1;
    bus.abort = 1'b0;
    chk("t5_abort_valid", 32'(bus.out_valid), 0);
    chk("t5_abort_ready", 32'(bus.cmd_ready), 1);
    chk("t5_abort_rd_en", 32'(bus.buf_rd_en_0), 0);
    bus.out_ready = 1'b1;
    clear_logs();
    send(11'h200, 10'd2, n);
    wait_idle(50);
    chk("t5_nbytes", 32'(byte_log.size()), 2);
    chk("t5_b0", 32'(byte_log[0]), 32'h0B);
    chk("t5_b1", 32'(byte_log[1]), 32'h30);

    // Asynchronous reset mid-packet.
    clear_logs();
    send(11'h040, 10'd6, n);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_ready", 32'(bus.cmd_ready), 1);
    chk("t6_rd_en", 32'(bus.buf_rd_en_0), 0);
    chk("t6_rd_addr", 32'(bus.buf_rd_addr_0), 0);
    chk("t6_out_data", 32'(bus.out_data), 0);
    chk("t6_out_last", 32'(bus.out_last), 0);
    chk("t6_done", 32'(bus.done), 0);
    clear_model();
    #12 rst_n = 1'b1;
    tick();
    chk("t6_post_valid", 32'(bus.out_valid), 0);
    clear_logs();
    send(11'h060, 10'd3, n);
    wait_idle(50);
    chk("t6_nbytes", 32'(byte_log.size()), 3);
    chk("t6_done_cyc", 32'(done_cyc), 32'(n + 6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
